// File: rtl/rib_rr_arbiter_pkg.sv
// rib_rr_arbiter_pkg: shared RIB bus widths, master indices and arbiter state encoding
package rib_rr_arbiter_pkg;
  localparam int RIB_ADDR_W = 32;
  localparam int RIB_DATA_W = 32;
  localparam int RIB_M_JTAG = 0;
  localparam int RIB_M_UART = 1;
  localparam int RIB_M_EX   = 2;
  localparam int RIB_M_PC   = 3;
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} arb_state_t;
endpackage

// File: rtl/rib_rr_arbiter_rr_pick.sv
// rib_rr_arbiter_rr_pick: combinational round-robin picker starting just after the last grant
module rib_rr_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);
  assign o_valid = |i_req;
  // scan farthest to nearest so the nearest requester after i_last is written last
  always_comb begin
    o_idx = '0;
    for (int k = N; k >= 1; k--) begin
      if (i_req[IW'((int'(i_last) + k) % N)]) o_idx = IW'((int'(i_last) + k) % N);
    end
  end
endmodule

// File: rtl/rib_rr_arbiter.sv
// rib_rr_arbiter: registered round-robin RIB master arbiter with slave ready handshake and timeout
module rib_rr_arbiter
  import rib_rr_arbiter_pkg::*;
#(
  parameter int               NUM_M       = 4,
  parameter logic [NUM_M-1:0] HOLD_MASK   = 4'b1100,
  parameter int               TIMEOUT_CYC = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_M-1:0]            m_req_i,
  input  logic [NUM_M-1:0]            m_we_i,
  input  logic [NUM_M*RIB_ADDR_W-1:0] m_addr_i,
  input  logic [NUM_M*RIB_DATA_W-1:0] m_wdata_i,
  output logic [NUM_M*RIB_DATA_W-1:0] m_rdata_o,
  output logic [NUM_M-1:0]            m_ack_o,
  output logic                        s_req_o,
  output logic                        s_we_o,
  output logic [RIB_ADDR_W-1:0]       s_addr_o,
  output logic [RIB_DATA_W-1:0]       s_wdata_o,
  input  logic [RIB_DATA_W-1:0]       s_rdata_i,
  input  logic                        s_ready_i,
  output logic                        err_o,
  output logic                        hold_flag_o
);
  localparam int IW = $clog2(NUM_M);
  localparam int TW = TIMEOUT_CYC < 2 ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC == 0 ? 0 : TIMEOUT_CYC - 1);

  arb_state_t    r_state, w_nxt;
  logic [IW-1:0] r_owner, r_last, w_pick;
  logic [TW-1:0] r_tmo;
  logic          w_valid, w_busy, w_ready, w_tmo, w_done;

  rib_rr_arbiter_rr_pick #(.N(NUM_M), .IW(IW)) u_pick (
    .i_req   (m_req_i),
    .i_last  (r_last),
    .o_valid (w_valid),
    .o_idx   (w_pick)
  );

  assign w_busy  = r_state == ST_BUSY;
  assign w_ready = w_busy & s_ready_i;
  // a ready slave always beats the timeout in the same cycle
  assign w_tmo   = w_busy & ~s_ready_i & (TIMEOUT_CYC != 0) & (r_tmo == TMO_LAST);
  assign w_done  = w_ready | w_tmo;

  always_comb begin
    w_nxt = r_state;
    if (!w_busy) w_nxt = w_valid ? ST_BUSY : ST_IDLE;
    else if (w_done) w_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
      r_last  <= IW'(NUM_M - 1);
      r_tmo   <= '0;
    end else begin
      r_state <= w_nxt;
      if (!w_busy && w_valid) begin
        r_owner <= w_pick;
        r_tmo   <= '0;
      end
      if (w_done) r_last <= r_owner;
      else if (w_busy && r_tmo != '1) r_tmo <= r_tmo + 1'b1;
    end
  end

  assign s_req_o   = w_busy;
  assign s_we_o    = w_busy & m_we_i[r_owner];
  assign s_addr_o  = w_busy ? m_addr_i[r_owner*RIB_ADDR_W +: RIB_ADDR_W] : '0;
  assign s_wdata_o = w_busy ? m_wdata_i[r_owner*RIB_DATA_W +: RIB_DATA_W] : '0;
  assign err_o     = w_tmo;

  always_comb begin
    m_ack_o = '0;
    m_rdata_o = '0;
    m_ack_o[r_owner] = w_done;
    m_rdata_o[r_owner*RIB_DATA_W +: RIB_DATA_W] = w_ready ? s_rdata_i : '0;
  end

  // gated by reset so every output reads 0 while rst is asserted
  assign hold_flag_o = rst & |(m_req_i & HOLD_MASK & ~m_ack_o);
endmodule

// File: tb/tb_rib_rr_arbiter.sv
// tb_rib_rr_arbiter: vector table, directed corner cases and random traffic against a reference model
module tb_rib_rr_arbiter;
  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   m_req_i = '0, m_we_i = '0;
  logic [127:0] m_addr_i = '0, m_wdata_i = '0;
  logic [127:0] m_rdata_o;
  logic [3:0]   m_ack_o;
  logic         s_req_o, s_we_o, s_ready_i = 1'b0, err_o, hold_flag_o;
  logic [31:0]  s_addr_o, s_wdata_o, s_rdata_i = '0;

  int checks = 0;
  int failures = 0;

  rib_rr_arbiter #(.NUM_M(4), .HOLD_MASK(4'b1100), .TIMEOUT_CYC(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .m_req_i     (m_req_i),
    .m_we_i      (m_we_i),
    .m_addr_i    (m_addr_i),
    .m_wdata_i   (m_wdata_i),
    .m_rdata_o   (m_rdata_o),
    .m_ack_o     (m_ack_o),
    .s_req_o     (s_req_o),
    .s_we_o      (s_we_o),
    .s_addr_o    (s_addr_o),
    .s_wdata_o   (s_wdata_o),
    .s_rdata_i   (s_rdata_i),
    .s_ready_i   (s_ready_i),
    .err_o       (err_o),
    .hold_flag_o (hold_flag_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [3:0] ack;
    logic       sreq;
    logic       hold;
  } vec_t;
  vec_t tbl[13];

  function automatic logic [255:0] pk(logic [3:0] ack, logic sreq, logic we, logic [31:0] a,
                                      logic [31:0] wd, logic err, logic hold, logic [127:0] rd);
    return {56'd0, ack, sreq, we, a, wd, err, hold, rd};
  endfunction

  task automatic chk(string nm, logic [255:0] a, logic [255:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic cmp(string nm, logic [255:0] e);
    chk(nm, pk(m_ack_o, s_req_o, s_we_o, s_addr_o, s_wdata_o, err_o, hold_flag_o, m_rdata_o), e);
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  bit          mb;
  int          mo, ml, mw, n_ack, hc;
  logic [3:0]  pend, e_ack;
  logic        e_err, e_hold, found;
  logic [127:0] e_rd;
  logic [31:0] ra[4], rwd[4];
  logic        rwe[4];

  initial begin
    tbl[0]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 1'b1};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 1'b1};
    tbl[3]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 1'b1};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 1'b1};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 1'b1};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 1'b1};
    tbl[7]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 1'b1};
    tbl[8]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 1'b1};
    tbl[9]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1};
    tbl[10] = '{4'b0011, 1'b1, 4'b0000, 1'b0, 1'b0};
    tbl[11] = '{4'b0011, 1'b1, 4'b0010, 1'b1, 1'b0};
    tbl[12] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};

    // reset held with every master requesting
    m_req_i = 4'b1111;
    m_addr_i = {4{32'hFACE_0000}};
    repeat (2) @(posedge clk);
    #1;
    cmp("reset_outs", '0);
    m_addr_i = '0;
    rst = 1'b1;

    // round robin from reset: grant order 0,1,2,3,0 then 0011 picks 1
    for (int i = 0; i < 13; i++) begin
      m_req_i = tbl[i].req;
      s_ready_i = tbl[i].rdy;
      s_rdata_i = 32'hC0DE_0000 + i;
      #1;
      e_rd = '0;
      for (int k = 0; k < 4; k++) if (tbl[i].ack[k]) e_rd[k*32 +: 32] = 32'hC0DE_0000 + i;
      cmp($sformatf("rr_vec%0d", i), pk(tbl[i].ack, tbl[i].sreq, 1'b0, '0, '0, 1'b0, tbl[i].hold, e_rd));
      nxt;
    end

    // wait states on master 2
    m_req_i = 4'b0100;
    m_addr_i[95:64] = 32'h1000_0004;
    s_ready_i = 1'b0;
    #1;
    cmp("ws_arb", pk(4'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, '0));
    hc = hold_flag_o ? 1 : 0;
    for (int c = 0; c < 5; c++) begin
      nxt;
      cmp("ws_busy", pk(4'b0, 1'b1, 1'b0, 32'h1000_0004, '0, 1'b0, 1'b1, '0));
      if (hold_flag_o) hc++;
    end
    nxt;
    s_ready_i = 1'b1;
    s_rdata_i = 32'hDEAD_BEEF;
    #1;
    cmp("ws_ack", pk(4'b0100, 1'b1, 1'b0, 32'h1000_0004, '0, 1'b0, 1'b0, {32'h0, 32'hDEAD_BEEF, 64'h0}));
    chk("ws_hold_cycles", 256'(hc), 256'd6);
    nxt;
    m_req_i = '0;
    s_ready_i = 1'b0;
    m_addr_i = '0;
    #1;
    cmp("ws_after", '0);

    // timeout on master 0, then ready in the timeout cycle
    m_req_i = 4'b0001;
    s_rdata_i = 32'hFFFF_FFFF;
    #1;
    cmp("tmo_arb", '0);
    for (int c = 1; c < TMO; c++) begin
      nxt;
      cmp("tmo_wait", pk(4'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0));
    end
    nxt;
    cmp("tmo_fire", pk(4'b0001, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0, '0));
    nxt;
    m_req_i = '0;
    #1;
    cmp("tmo_idle", '0);
    m_req_i = 4'b0001;
    for (int c = 1; c < TMO; c++) begin
      nxt;
      cmp("tmo2_wait", pk(4'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0));
    end
    nxt;
    s_ready_i = 1'b1;
    s_rdata_i = 32'h0000_5A5A;
    #1;
    cmp("tmo_rdy_wins", pk(4'b0001, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, {96'h0, 32'h0000_5A5A}));
    nxt;
    m_req_i = '0;
    s_ready_i = 1'b0;

    // write pass-through from master 3 with distinct data on the others
    m_req_i = 4'b1000;
    m_we_i = 4'b1000;
    m_addr_i = {32'h2000_0000, 32'h2222_2222, 32'h1111_1111, 32'h0BAD_0000};
    m_wdata_i = {32'h1234_5678, 32'hBBBB_BBBB, 32'hAAAA_AAAA, 32'h9999_9999};
    #1;
    cmp("wr_arb", pk(4'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, '0));
    for (int c = 0; c < 2; c++) begin
      nxt;
      cmp("wr_busy", pk(4'b0, 1'b1, 1'b1, 32'h2000_0000, 32'h1234_5678, 1'b0, 1'b1, '0));
    end
    nxt;
    s_ready_i = 1'b1;
    s_rdata_i = 32'h77;
    #1;
    cmp("wr_ack", pk(4'b1000, 1'b1, 1'b1, 32'h2000_0000, 32'h1234_5678, 1'b0, 1'b0, {32'h77, 96'h0}));
    nxt;
    m_req_i = '0;
    m_we_i = '0;
    m_addr_i = '0;
    m_wdata_i = '0;
    s_ready_i = 1'b0;

    // reset in the third wait cycle of master 1
    m_req_i = 4'b0010;
    repeat (3) nxt;
    cmp("mid_busy", pk(4'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0));
    #1;
    rst = 1'b0;
    #1;
    cmp("rst_async", '0);
    m_req_i = 4'b1111;
    nxt;
    cmp("rst_hold", '0);
    rst = 1'b1;
    s_ready_i = 1'b1;
    s_rdata_i = 32'h0BAD_F00D;
    #1;
    cmp("rst_rel_arb", pk(4'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, '0));
    nxt;
    cmp("rst_rel_m0", pk(4'b0001, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1, {96'h0, 32'h0BAD_F00D}));
    nxt;
    m_req_i = '0;
    s_ready_i = 1'b0;

    // random traffic against the reference model
    rst = 1'b0;
    nxt;
    rst = 1'b1;
    mb = 1'b0;
    mo = 0;
    ml = 3;
    mw = 0;
    pend = '0;
    n_ack = 0;
    for (int k = 0; k < 4; k++) begin
      ra[k] = '0;
      rwd[k] = '0;
      rwe[k] = 1'b0;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int k = 0; k < 4; k++) begin
        if (!pend[k] && $urandom_range(0, 2) == 0) begin
          pend[k] = 1'b1;
          ra[k] = $urandom;
          rwd[k] = $urandom;
          rwe[k] = 1'($urandom_range(0, 1));
        end
        m_addr_i[k*32 +: 32] = ra[k];
        m_wdata_i[k*32 +: 32] = rwd[k];
        m_we_i[k] = rwe[k];
      end
      m_req_i = pend;
      s_ready_i = $urandom_range(0, 9) < 3;
      s_rdata_i = $urandom;
      #1;
      e_ack = '0;
      e_err = 1'b0;
      e_rd = '0;
      if (mb) begin
        if (s_ready_i) begin
          e_ack[mo] = 1'b1;
          e_rd[mo*32 +: 32] = s_rdata_i;
        end else if (mw == TMO - 1) begin
          e_ack[mo] = 1'b1;
          e_err = 1'b1;
        end
      end
      e_hold = |(pend & 4'b1100 & ~e_ack);
      cmp($sformatf("rand_c%0d", cyc), pk(e_ack, mb, mb ? rwe[mo] : 1'b0, mb ? ra[mo] : 32'h0,
          mb ? rwd[mo] : 32'h0, e_err, e_hold, e_rd));
      if (!mb) begin
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          if (!found && pend[(ml + k) % 4]) begin
            mo = (ml + k) % 4;
            found = 1'b1;
          end
        end
        if (found) begin
          mb = 1'b1;
          mw = 0;
        end
      end else if (|e_ack) begin
        mb = 1'b0;
        ml = mo;
        pend[mo] = 1'b0;
        n_ack++;
      end else begin
        mw++;
      end
      nxt;
    end
    chk("rand_progress", 256'(n_ack > 100), 256'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
